// File: rtl/uart_cmd_decoder_if.sv
// =============================================================================
// Module : uart_cmd_decoder_if
// Brief  : Receive, transmit and register-file signals of the command decoder.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

interface uart_cmd_decoder_if;
  logic [17:0] rx_data;
  logic        rx_empty;
  logic        uld_rx_data;
  logic [17:0] tx_data;
  logic        ld_tx_data;
  logic        tx_busy;
  logic [7:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_we;
  logic [7:0]  reg_rdata;
  logic [7:0]  perr_cnt;
  logic [7:0]  aerr_cnt;

  // Decoder side.
  modport master (
    input  rx_data, rx_empty, tx_busy, reg_rdata,
    output uld_rx_data, tx_data, ld_tx_data, reg_addr, reg_wdata, reg_we,
           perr_cnt, aerr_cnt
  );

  // UART and register-file side.
  modport slave (
    output rx_data, rx_empty, tx_busy, reg_rdata,
    input  uld_rx_data, tx_data, ld_tx_data, reg_addr, reg_wdata, reg_we,
           perr_cnt, aerr_cnt
  );
endinterface

`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
// =============================================================================
// Module : uart_cmd_decoder
// Brief  : Unloads UART frames, checks parity, does config register writes and
//          reads, and queues read replies. UART_CMD_ECHO_EN adds write echoes.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module uart_cmd_decoder #(
  parameter int NUMREGS = 9
) (
  input  wire                  clk,
  input  wire                  reset_n,
  uart_cmd_decoder_if.master   cmd_if
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_UNLOAD  = 3'd1,
    S_CAPTURE = 3'd2,
    S_DECODE  = 3'd3,
    S_WRITE   = 3'd4,
    S_READ    = 3'd5,
    S_TX_WAIT = 3'd6,
    S_TX_HOLD = 3'd7
  } state_t;

  localparam logic [8:0] C_NUMREGS = 9'(NUMREGS);

  state_t      state_q, state_d;
  logic [17:0] frame_q, frame_d;
  logic [17:0] reply_q, reply_d;
  logic        perr_inc_q, perr_inc_d;
  logic        aerr_inc_q, aerr_inc_d;
  logic [7:0]  perr_cnt_q;
  logic [7:0]  aerr_cnt_q;

  logic [7:0]  w_addr;
  logic [7:0]  w_data;
  logic        w_wrb;
  logic        w_par_bad;
  logic        w_addr_oob;

  assign w_addr     = frame_q[16:9];
  assign w_data     = frame_q[8:1];
  assign w_wrb      = frame_q[0];
  assign w_par_bad  = ^frame_q;
  assign w_addr_oob = ({1'b0, w_addr} >= C_NUMREGS);

  // Reply frames carry even parity across all 18 bits.
  function automatic logic [17:0] mk_frame(input logic [7:0] addr,
                                           input logic [7:0] data,
                                           input logic       wrb);
    mk_frame = {^{addr, data, wrb}, addr, data, wrb};
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      frame_q    <= '0;
      reply_q    <= '0;
      perr_inc_q <= 1'b0;
      aerr_inc_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      reply_q    <= reply_d;
      perr_inc_q <= perr_inc_d;
      aerr_inc_q <= aerr_inc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    reply_d    = reply_q;
    perr_inc_d = 1'b0;
    aerr_inc_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!cmd_if.rx_empty) state_d = S_UNLOAD;
      end
      S_UNLOAD: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        frame_d = cmd_if.rx_data;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (w_par_bad) begin
          perr_inc_d = 1'b1;
          state_d    = S_IDLE;
        end else if (w_addr_oob) begin
          aerr_inc_d = 1'b1;
          if (w_wrb) begin
            reply_d = mk_frame(w_addr, 8'h00, 1'b1);
            state_d = S_TX_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end else if (w_wrb) begin
          state_d = S_READ;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
`ifdef UART_CMD_ECHO_EN
        reply_d = mk_frame(w_addr, w_data, 1'b0);
        state_d = S_TX_WAIT;
`else
        state_d = S_IDLE;
`endif
      end
      S_READ: begin
        reply_d = mk_frame(w_addr, cmd_if.reg_rdata, 1'b1);
        state_d = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (!cmd_if.tx_busy) state_d = S_TX_HOLD;
      end
      S_TX_HOLD: begin
        // Hold the load request until a slow-clocked transmitter acknowledges.
        if (cmd_if.tx_busy) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Counter updates trail the decode decision by one edge; both saturate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perr_cnt_q <= 8'h00;
      aerr_cnt_q <= 8'h00;
    end else begin
      if (perr_inc_q && (perr_cnt_q != 8'hFF)) perr_cnt_q <= perr_cnt_q + 8'h01;
      if (aerr_inc_q && (aerr_cnt_q != 8'hFF)) aerr_cnt_q <= aerr_cnt_q + 8'h01;
    end
  end

  assign cmd_if.uld_rx_data = (state_q == S_UNLOAD);
  assign cmd_if.reg_we      = (state_q == S_WRITE);
  assign cmd_if.ld_tx_data  = (state_q == S_TX_HOLD);
  assign cmd_if.reg_addr    = w_addr;
  assign cmd_if.reg_wdata   = w_data;
  assign cmd_if.tx_data     = reply_q;
  assign cmd_if.perr_cnt    = perr_cnt_q;
  assign cmd_if.aerr_cnt    = aerr_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
// =============================================================================
// Module : tb_uart_cmd_decoder
// Brief  : Directed bench for uart_cmd_decoder with hand-computed frames.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module tb_uart_cmd_decoder;

  logic clk;
  logic reset_n;
  int   cyc;
  int   n_vec;
  int   n_err;

  uart_cmd_decoder_if u_if ();

  uart_cmd_decoder #(.NUMREGS(9)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cmd_if  (u_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file: read data registered one cycle after the address.
  logic [7:0] regs [0:15];
  always @(posedge clk) begin
    if (u_if.reg_we) regs[u_if.reg_addr[3:0]] <= u_if.reg_wdata;
    u_if.reg_rdata <= regs[u_if.reg_addr[3:0]];
  end

  int          uld_cnt, uld_cyc, we_cnt, we_cyc, ld_cnt, ld_cyc, unstable;
  logic [7:0]  we_addr, we_data;
  logic [17:0] ld_data;
  logic        ld_prev;

  always @(negedge clk) begin
    if (u_if.uld_rx_data) begin
      uld_cnt <= uld_cnt + 1;
      uld_cyc <= cyc;
    end
    if (u_if.reg_we) begin
      we_cnt  <= we_cnt + 1;
      we_cyc  <= cyc;
      we_addr <= u_if.reg_addr;
      we_data <= u_if.reg_wdata;
    end
    if (u_if.ld_tx_data && !ld_prev) begin
      ld_cnt  <= ld_cnt + 1;
      ld_cyc  <= cyc;
      ld_data <= u_if.tx_data;
    end else if (u_if.ld_tx_data && (u_if.tx_data != ld_data)) begin
      unstable <= unstable + 1;
    end
    ld_prev <= u_if.ld_tx_data;
  end

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick();
  endtask

  // Returns k, the edge where IDLE first sees rx_empty low.
  task automatic send_frame(input logic [17:0] frame, output int k, output bit ok);
    @(posedge clk);
    #1;
    u_if.rx_data  = frame;
    u_if.rx_empty = 1'b0;
    k  = cyc + 1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (u_if.uld_rx_data) ok = 1'b1;
    end
    u_if.rx_empty = 1'b1;
  endtask

  task automatic expect_reply(input string tag, input logic [17:0] exp);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      if (u_if.ld_tx_data) seen = 1'b1;
      else tick();
    end
    check_val({tag, "_ld"}, 32'(seen), 32'd1);
    check_val({tag, "_txdata"}, 32'(u_if.tx_data), 32'(exp));
    repeat (3) tick();
    check_val({tag, "_ldhold"}, 32'(u_if.ld_tx_data), 32'd1);
    u_if.tx_busy = 1'b1;
    tick();
    check_val({tag, "_lddrop"}, 32'(u_if.ld_tx_data), 32'd0);
    repeat (2) tick();
    u_if.tx_busy = 1'b0;
    tick();
  endtask

  task automatic do_write(input string tag, input logic [17:0] frame,
                          input logic [7:0] ea, input logic [7:0] ed);
    int k, we0, ld0;
    bit ok;
    we0 = we_cnt;
    ld0 = ld_cnt;
    send_frame(frame, k, ok);
    check_val({tag, "_unload"}, 32'(ok), 32'd1);
    check_val({tag, "_uldcyc"}, 32'(uld_cyc - k + 1), 32'd1);
`ifdef UART_CMD_ECHO_EN
    expect_reply({tag, "_echo"}, frame);
`else
    wait_cyc(k + 8);
    check_val({tag, "_noreply"}, 32'(ld_cnt - ld0), 32'd0);
`endif
    check_val({tag, "_wecnt"}, 32'(we_cnt - we0), 32'd1);
    check_val({tag, "_wecyc"}, 32'(we_cyc - k + 1), 32'd4);
    check_val({tag, "_weaddr"}, 32'(we_addr), 32'(ea));
    check_val({tag, "_wedata"}, 32'(we_data), 32'(ed));
  endtask

  task automatic do_read(input string tag, input logic [17:0] frame,
                         input logic [17:0] reply, input int ld_rel);
    int k;
    bit ok;
    send_frame(frame, k, ok);
    check_val({tag, "_unload"}, 32'(ok), 32'd1);
    expect_reply(tag, reply);
    check_val({tag, "_ldcyc"}, 32'(ld_cyc - k + 1), 32'(ld_rel));
  endtask

  initial begin
    int  k, ld0, we0, bad, fails;
    bit  ok;
    n_vec = 0; n_err = 0; cyc = 0;
    uld_cnt = 0; we_cnt = 0; ld_cnt = 0; unstable = 0; ld_prev = 1'b0;
    u_if.rx_data  = '0;
    u_if.rx_empty = 1'b1;
    u_if.tx_busy  = 1'b0;
    reset_n = 1'b0;
    repeat (3) tick();
    check_val("rst_uld",  32'(u_if.uld_rx_data), 32'd0);
    check_val("rst_we",   32'(u_if.reg_we), 32'd0);
    check_val("rst_ld",   32'(u_if.ld_tx_data), 32'd0);
    check_val("rst_txd",  32'(u_if.tx_data), 32'd0);
    check_val("rst_addr", 32'(u_if.reg_addr), 32'd0);
    check_val("rst_perr", 32'(u_if.perr_cnt), 32'd0);
    check_val("rst_aerr", 32'(u_if.aerr_cnt), 32'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Write 0x03 <- 0xA5: six ones in addr/data, parity 0.
    do_write("wr03", 18'h0074A, 8'h03, 8'hA5);
    // Read 0x03: reply has seven ones in the low 17 bits, so parity is 1.
    do_read("rd03", 18'h20601, 18'h2074B, 6);

    // Bad parity: same write frame with bit 17 flipped.
    ld0 = ld_cnt; we0 = we_cnt;
    send_frame(18'h2074A, k, ok);
    wait_cyc(k + 3);
    check_val("perr_pre", 32'(u_if.perr_cnt), 32'd0);
    tick();
    check_val("perr_one", 32'(u_if.perr_cnt), 32'd1);
    wait_cyc(k + 8);
    check_val("perr_nowe", 32'(we_cnt - we0), 32'd0);
    check_val("perr_nold", 32'(ld_cnt - ld0), 32'd0);
    fails = 0;
    for (int i = 0; i < 299; i++) begin
      send_frame(18'h2074A, k, ok);
      if (!ok) fails++;
      wait_cyc(k + 5);
    end
    check_val("perr_unloads", 32'(fails), 32'd0);
    check_val("perr_sat", 32'(u_if.perr_cnt), 32'd255);

    // Reset during TX_WAIT of a read: reply must be discarded.
    ld0 = ld_cnt;
    send_frame(18'h20601, k, ok);
    wait_cyc(k + 4);
    reset_n = 1'b0;
    #1;
    check_val("arst_txd",  32'(u_if.tx_data), 32'd0);
    check_val("arst_perr", 32'(u_if.perr_cnt), 32'd0);
    repeat (2) tick();
    check_val("arst_ld",    32'(u_if.ld_tx_data), 32'd0);
    check_val("arst_ldcnt", 32'(ld_cnt - ld0), 32'd0);
    check_val("arst_addr",  32'(u_if.reg_addr), 32'd0);
    reset_n = 1'b1;
    repeat (2) tick();
    do_read("rd03_post", 18'h20601, 18'h2074B, 6);

    // Out-of-range read at NUMREGS: reply data 0x00, DECODE goes straight to TX_WAIT.
    do_read("rd09", 18'h21201, 18'h21201, 5);
    check_val("aerr_one", 32'(u_if.aerr_cnt), 32'd1);
    we0 = we_cnt; ld0 = ld_cnt;
    send_frame(18'h24022, k, ok);
    wait_cyc(k + 8);
    check_val("aerr_two",  32'(u_if.aerr_cnt), 32'd2);
    check_val("wr20_nowe", 32'(we_cnt - we0), 32'd0);
    check_val("wr20_nold", 32'(ld_cnt - ld0), 32'd0);

    // Highest valid address.
    do_write("wr08", 18'h210B4, 8'h08, 8'h5A);
    do_read("rd08", 18'h01001, 18'h010B5, 6);

    // Busy transmitter for 50 cycles.
    u_if.tx_busy = 1'b1;
    send_frame(18'h20601, k, ok);
    bad = 0; fails = 0;
    for (int i = 0; i < 50; i++) begin
      if (u_if.ld_tx_data) bad++;
      if (i >= 6 && u_if.tx_data != 18'h2074B) fails++;
      tick();
    end
    check_val("busy_nold",   32'(bad), 32'd0);
    check_val("busy_stable", 32'(fails), 32'd0);
    u_if.tx_busy = 1'b0;
    expect_reply("busy_rd", 18'h2074B);

`ifdef UART_CMD_ECHO_EN
    do_write("wr01_echo", 18'h20278, 8'h01, 8'h3C);
`endif

    check_val("tx_stable", 32'(unstable), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
